// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: frames a valid/ready bit stream into FRAME_BITS-bit frames and sequences the serial CRC-8 checker.
// Latency: frame_done_o rises FLAG_LAT+1 cycles after the last accepted bit; frames are separated by FLAG_LAT+1 not-ready cycles.
// Backpressure: bit_ready_o is high only in SHIFT while enable_i is high; upstream holds bit_i/bit_valid_i until accepted.
//
// Ports: clk_i/rst_i (sync active-high reset); enable_i level run/abort; bit_i/bit_valid_i/bit_ready_o input stream;
//        crc_clr_o/crc_en_o/crc_data_o/crc_capture_o drive the checker, crc_flag_i is its mismatch result;
//        frame_done_o/frame_ok_o per-frame result; frame_cnt_o/err_cnt_o saturating counters; locked_o stop-on-error status.
// Build option: define CRC_FRAME_CTRL_STOP_ON_ERR_EN to lock up after the first failed frame until rst_i.
module crc_frame_ctrl #(
    parameter int FRAME_BITS = 72,
    parameter int FLAG_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic             crc_clr_o,
    output logic             crc_en_o,
    output logic             crc_data_o,
    output logic             crc_capture_o,
    input  logic             crc_flag_i,
    output logic             frame_done_o,
    output logic             frame_ok_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             locked_o
);

    localparam int BW = $clog2(FRAME_BITS);
    localparam int WW = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(FLAG_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_DONE,
        S_LOCK
    } state_t;

    state_t           r_state;
    logic [BW-1:0]    r_bit_cnt;
    logic [WW-1:0]    r_wait_cnt;
    logic             r_ready;
    logic             r_clr;
    logic             r_done;
    logic             r_ok;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
    logic             r_locked;
`endif

    logic w_accept;
    logic w_last;

    // Ready is qualified by enable_i so that a bit offered in the abort cycle
    // is never handshaken and then silently dropped; this also guarantees no
    // capture strobe can fire in the cycle the frame is being abandoned.
    assign bit_ready_o   = r_ready & enable_i;
    assign w_accept      = bit_valid_i & bit_ready_o;
    assign w_last        = (r_bit_cnt == LAST_BIT);
    assign crc_data_o    = bit_i & bit_ready_o;
    assign crc_en_o      = w_accept & ~w_last;
    assign crc_capture_o = w_accept & w_last;
    assign crc_clr_o     = r_clr;
    assign frame_done_o  = r_done;
    assign frame_ok_o    = r_ok;
    assign frame_cnt_o   = r_frame_cnt;
    assign err_cnt_o     = r_err_cnt;
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
    assign locked_o      = r_locked;
`else
    assign locked_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_ready     <= 1'b0;
            r_clr       <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
            r_locked    <= 1'b0;
`endif
        end else begin
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_state   <= S_SHIFT;
                        r_clr     <= 1'b1;
                        r_ready   <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!enable_i) begin
                        // Abort: drop the partial frame, results untouched.
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_state    <= S_WAIT;
                            r_ready    <= 1'b0;
                            r_bit_cnt  <= '0;
                            r_wait_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == LAST_WAIT) begin
                        // Counters are updated here so they already show the
                        // new totals while frame_done_o is high.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ok    <= ~crc_flag_i;
                        if (r_frame_cnt != CNT_MAX) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                        if (crc_flag_i && (r_err_cnt != CNT_MAX)) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
                    if (!r_ok) begin
                        r_state  <= S_LOCK;
                        r_locked <= 1'b1;
                    end else
`endif
                    if (enable_i) begin
                        r_state <= S_SHIFT;
                        r_clr   <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
                S_LOCK: begin
                    r_state <= S_LOCK;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: randomized, self-checking bench for crc_frame_ctrl.
// Latency: n/a (bench).
// Backpressure: bench drives bit_valid_i randomly and honours bit_ready_o.
module tb_crc_frame_ctrl;

    localparam int FRAME_BITS = 72;
    localparam int FLAG_LAT   = 1;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             enable_i = 1'b0;
    logic             bit_i = 1'b0;
    logic             bit_valid_i = 1'b0;
    logic             crc_flag_i = 1'b0;
    logic             bit_ready_o;
    logic             crc_clr_o;
    logic             crc_en_o;
    logic             crc_data_o;
    logic             crc_capture_o;
    logic             frame_done_o;
    logic             frame_ok_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             locked_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_frame_ctrl #(
        .FRAME_BITS(FRAME_BITS),
        .FLAG_LAT  (FLAG_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .crc_clr_o    (crc_clr_o),
        .crc_en_o     (crc_en_o),
        .crc_data_o   (crc_data_o),
        .crc_capture_o(crc_capture_o),
        .crc_flag_i   (crc_flag_i),
        .frame_done_o (frame_done_o),
        .frame_ok_o   (frame_ok_o),
        .frame_cnt_o  (frame_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .locked_o     (locked_o)
    );

    // Passive observer: accumulates what the checker-side interface saw.
    int               cyc = 0;
    int               clr_cnt = 0;
    int               en_cnt = 0;
    int               acc_cnt = 0;
    int               cap_cnt = 0;
    int               done_cnt = 0;
    int               last_cap_acc = 0;
    int               last_cap_cyc = 0;
    int               last_done_cyc = 0;
    logic             last_ok = 1'b0;
    logic [CNT_W-1:0] last_fcnt = '0;
    logic [CNT_W-1:0] last_ecnt = '0;
    int               low_run = 0;
    bit               cap_bits[$];
    int               gaps[$];

    always @(negedge clk) begin
        cyc++;
        if (crc_clr_o) clr_cnt++;
        if (crc_en_o) en_cnt++;
        if (bit_valid_i && bit_ready_o) acc_cnt++;
        if (crc_en_o || crc_capture_o) cap_bits.push_back(crc_data_o);
        if (crc_capture_o) begin
            cap_cnt++;
            last_cap_acc = acc_cnt;
            last_cap_cyc = cyc;
        end
        if (frame_done_o) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_ok = frame_ok_o;
            last_fcnt = frame_cnt_o;
            last_ecnt = err_cnt_o;
        end
        if (!bit_ready_o) begin
            low_run++;
        end else begin
            if (low_run > 0) gaps.push_back(low_run);
            low_run = 0;
        end
    end

    bit sent[$];

    // Offers bits until n are accepted; flag is the stub checker result for this frame.
    task automatic send_bits(input int n, input int stall_pct, input bit flag);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 5000) begin
            @(posedge clk);
            #1;
            // Set after the previous frame's flag sample edge has passed.
            if (guard == 0) crc_flag_i = flag;
            bit_valid_i = ($urandom_range(99) >= stall_pct);
            bit_i = 1'($urandom_range(1));
            @(negedge clk);
            if (bit_valid_i && bit_ready_o) begin
                sent.push_back(bit_i);
                got++;
            end
            guard++;
        end
        @(posedge clk);
        #1;
        bit_valid_i = 1'b0;
        checks++;
        if (got !== n) begin
            errors++;
            $display("FAIL send_bits_timeout accepted=%0d required=%0d", got, n);
        end
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cnt < target && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done_timeout done=%0d required=%0d", done_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        enable_i = 1'b0;
        bit_valid_i = 1'b0;
        crc_flag_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    // Mismatches between what reached the checker and what was accepted from the stream.
    function automatic int seq_diff(input int base);
        int d = 0;
        if (cap_bits.size() - base != sent.size()) return -1;
        for (int i = 0; i < sent.size(); i++)
            if (cap_bits[base + i] != sent[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        enable_i = 1'b1;
        bit_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bit_ready_o, crc_clr_o, crc_en_o, crc_data_o, crc_capture_o, frame_done_o, frame_ok_o, locked_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b required=00000000",
                     {bit_ready_o, crc_clr_o, crc_en_o, crc_data_o, crc_capture_o, frame_done_o, frame_ok_o, locked_o});
        end
        checks++;
        if (frame_cnt_o !== '0 || err_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_counters frame=%0d err=%0d required=0,0", frame_cnt_o, err_cnt_o);
        end
        enable_i = 1'b0;
        bit_i = 1'b0;
        do_reset();
    endtask

    task automatic test_single_frame();
        int c0, e0, k0, a0, b0, d0;
        do_reset();
        c0 = clr_cnt; e0 = en_cnt; k0 = cap_cnt; a0 = acc_cnt; b0 = cap_bits.size(); d0 = done_cnt;
        sent.delete();
        enable_i = 1'b1;
        send_bits(FRAME_BITS, 0, 1'b0);
        enable_i = 1'b0;
        wait_done(d0 + 1);
        checks++;
        if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL single_clr got=%0d required=1", clr_cnt - c0); end
        checks++;
        if (en_cnt - e0 !== FRAME_BITS - 1) begin errors++; $display("FAIL single_en got=%0d required=%0d", en_cnt - e0, FRAME_BITS - 1); end
        checks++;
        if (cap_cnt - k0 !== 1 || last_cap_acc - a0 !== FRAME_BITS) begin
            errors++;
            $display("FAIL single_capture count=%0d at_bit=%0d required=1,%0d", cap_cnt - k0, last_cap_acc - a0, FRAME_BITS);
        end
        checks++;
        if (last_done_cyc - last_cap_cyc !== FLAG_LAT + 1) begin
            errors++;
            $display("FAIL single_latency got=%0d required=%0d", last_done_cyc - last_cap_cyc, FLAG_LAT + 1);
        end
        checks++;
        if (last_ok !== 1'b1 || last_fcnt !== 16'd1 || last_ecnt !== 16'd0) begin
            errors++;
            $display("FAIL single_result ok=%b frames=%0d errs=%0d required=1,1,0", last_ok, last_fcnt, last_ecnt);
        end
        checks++;
        if (seq_diff(b0) !== 0) begin errors++; $display("FAIL single_data diff=%0d required=0", seq_diff(b0)); end
    endtask

    task automatic test_back_to_back();
        bit flags[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int d0, g0, nerr;
        do_reset();
        d0 = done_cnt; g0 = gaps.size(); nerr = 0;
        enable_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bits(FRAME_BITS, 0, flags[i]);
            nerr += int'(flags[i]);
        end
        enable_i = 1'b0;
        wait_done(d0 + 5);
        checks++;
        if (last_fcnt !== 16'(5) || last_ecnt !== 16'(nerr) || last_ok !== !flags[4]) begin
            errors++;
            $display("FAIL b2b_result frames=%0d errs=%0d ok=%b required=5,%0d,%b", last_fcnt, last_ecnt, last_ok, nerr, !flags[4]);
        end
        checks++;
        if (done_cnt - d0 !== 5) begin errors++; $display("FAIL b2b_done got=%0d required=5", done_cnt - d0); end
        checks++;
        if (gaps.size() - g0 !== 5) begin
            errors++;
            $display("FAIL b2b_gap_count got=%0d required=5", gaps.size() - g0);
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (gaps[g0 + i] !== FLAG_LAT + 1) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got=%0d required=%0d", i, gaps[g0 + i], FLAG_LAT + 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int it = 0; it < 3; it++) begin
            int e0, k0, a0, b0, d0;
            bit flag;
            do_reset();
            e0 = en_cnt; k0 = cap_cnt; a0 = acc_cnt; b0 = cap_bits.size(); d0 = done_cnt;
            flag = 1'($urandom_range(1));
            sent.delete();
            enable_i = 1'b1;
            send_bits(FRAME_BITS, 50, flag);
            enable_i = 1'b0;
            wait_done(d0 + 1);
            checks++;
            if (cap_cnt - k0 !== 1 || last_cap_acc - a0 !== FRAME_BITS || en_cnt - e0 !== FRAME_BITS - 1) begin
                errors++;
                $display("FAIL stall_strobes caps=%0d at_bit=%0d en=%0d required=1,%0d,%0d",
                         cap_cnt - k0, last_cap_acc - a0, en_cnt - e0, FRAME_BITS, FRAME_BITS - 1);
            end
            checks++;
            if (seq_diff(b0) !== 0) begin errors++; $display("FAIL stall_data diff=%0d required=0", seq_diff(b0)); end
            checks++;
            if (last_ok !== !flag || last_ecnt !== 16'(flag)) begin
                errors++;
                $display("FAIL stall_result ok=%b errs=%0d required=%b,%0d", last_ok, last_ecnt, !flag, flag);
            end
        end
    endtask

    task automatic test_abort();
        int c0, k0, a0, b0, d0;
        do_reset();
        k0 = cap_cnt; d0 = done_cnt;
        sent.delete();
        enable_i = 1'b1;
        send_bits(40, 0, 1'b0);
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (cap_cnt - k0 !== 0 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL abort_strobes caps=%0d dones=%0d required=0,0", cap_cnt - k0, done_cnt - d0);
        end
        checks++;
        if (frame_cnt_o !== '0 || err_cnt_o !== '0 || frame_ok_o !== 1'b0 || bit_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_state frames=%0d errs=%0d ok=%b rdy=%b required=0,0,0,0", frame_cnt_o, err_cnt_o, frame_ok_o, bit_ready_o);
        end
        c0 = clr_cnt; a0 = acc_cnt; b0 = cap_bits.size(); d0 = done_cnt;
        sent.delete();
        enable_i = 1'b1;
        send_bits(FRAME_BITS, 20, 1'b0);
        enable_i = 1'b0;
        wait_done(d0 + 1);
        checks++;
        if (clr_cnt - c0 !== 1 || last_cap_acc - a0 !== FRAME_BITS) begin
            errors++;
            $display("FAIL abort_restart clr=%0d at_bit=%0d required=1,%0d", clr_cnt - c0, last_cap_acc - a0, FRAME_BITS);
        end
        checks++;
        if (seq_diff(b0) !== 0 || last_fcnt !== 16'd1 || last_ok !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_frame diff=%0d frames=%0d ok=%b required=0,1,1", seq_diff(b0), last_fcnt, last_ok);
        end
    endtask

    task automatic test_reset_mid();
        int a0, d0;
        do_reset();
        sent.delete();
        enable_i = 1'b1;
        send_bits(30, 0, 1'b0);
        rst_i = 1'b1;
        bit_valid_i = 1'b1;
        bit_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bit_ready_o, crc_clr_o, crc_en_o, crc_data_o, crc_capture_o, frame_done_o, frame_ok_o, locked_o} !== 8'h00
            || frame_cnt_o !== '0 || err_cnt_o !== '0) begin
            errors++;
            $display("FAIL midreset_outputs flags=%b frames=%0d errs=%0d required=0",
                     {bit_ready_o, crc_clr_o, crc_en_o, crc_data_o, crc_capture_o, frame_done_o, frame_ok_o, locked_o},
                     frame_cnt_o, err_cnt_o);
        end
        #1;
        bit_valid_i = 1'b0;
        rst_i = 1'b0;
        a0 = acc_cnt; d0 = done_cnt;
        sent.delete();
        send_bits(FRAME_BITS, 0, 1'b0);
        enable_i = 1'b0;
        wait_done(d0 + 1);
        checks++;
        if (last_fcnt !== 16'd1 || last_ok !== 1'b1 || last_cap_acc - a0 !== FRAME_BITS) begin
            errors++;
            $display("FAIL midreset_next frames=%0d ok=%b at_bit=%0d required=1,1,%0d", last_fcnt, last_ok, last_cap_acc - a0, FRAME_BITS);
        end
    endtask

`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
    task automatic test_lock();
        int d0, rdy_hi;
        do_reset();
        d0 = done_cnt; rdy_hi = 0;
        enable_i = 1'b1;
        send_bits(FRAME_BITS, 0, 1'b0);
        send_bits(FRAME_BITS, 0, 1'b1);
        wait_done(d0 + 2);
        @(negedge clk);
        checks++;
        if (err_cnt_o !== 16'd1 || locked_o !== 1'b1 || frame_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL lock_entry errs=%0d locked=%b frames=%0d required=1,1,2", err_cnt_o, locked_o, frame_cnt_o);
        end
        bit_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bit_ready_o) rdy_hi++;
        end
        bit_valid_i = 1'b0;
        checks++;
        if (rdy_hi !== 0) begin errors++; $display("FAIL lock_ready got=%0d required=0", rdy_hi); end
        do_reset();
        @(negedge clk);
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_release got=%b required=0", locked_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_mid();
`ifdef CRC_FRAME_CTRL_STOP_ON_ERR_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
